// File: rtl/dcache_core.sv
// dcache_core: direct-mapped, one-word-per-line, write-through, no-write-allocate
// data cache sitting between a CPU memory unit and a backing memory.
// Optional build macro: DCACHE_STATS_EN adds read hit/miss counters.

package dcache_interface;
  typedef struct packed {
    logic        valid;
    logic        rw;      // 1 = write
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] wmask;   // only [3:0] meaningful
  } cpu_req_t;

  typedef struct packed {
    logic        ready;
    logic [31:0] data;
  } cpu_res_t;
endpackage

module dcache_core
  import dcache_interface::*;
#(
  parameter int NUM_LINES = 16
) (
  input  logic     clk,
  input  logic     rst,
  input  cpu_req_t cpu_req,
  output cpu_res_t cpu_res,
  output cpu_req_t mem_req,
  input  cpu_res_t mem_res
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int IDX   = $clog2(NUM_LINES);
  localparam int TAG_W = 30 - IDX;

  typedef enum logic [2:0] {IDLE, LOOKUP, MEM_RD, MEM_WR, RESP} state_t;

  state_t               state;
  logic [31:0]          line_data [NUM_LINES];
  logic [TAG_W-1:0]     line_tag  [NUM_LINES];
  logic [NUM_LINES-1:0] line_vld;

  // latched request; the byte offset is never needed so only the word address is kept
  logic        r_rw;
  logic [29:0] r_addr;
  logic [31:0] r_data;
  logic [31:0] r_wmask;

  logic [IDX-1:0]   idx;
  logic [TAG_W-1:0] tag;
  logic             hit;
  logic [31:0]      merged;
  logic             wr_hit;
  logic             fill;

  assign idx    = r_addr[IDX-1:0];
  assign tag    = r_addr[29:IDX];
  assign hit    = line_vld[idx] && (line_tag[idx] == tag);
  assign wr_hit = (state == LOOKUP) && r_rw && hit;
  assign fill   = (state == MEM_RD) && mem_res.ready;

  // byte-merge of the latched write data over the currently stored word
  always_comb begin
    merged = line_data[idx];
    for (int b = 0; b < 4; b++)
      if (r_wmask[b]) merged[8*b +: 8] = r_data[8*b +: 8];
  end

  // line storage: write-hit merge or miss fill; validity is tracked separately so no reset here
  always_ff @(posedge clk) begin
    if (wr_hit) line_data[idx] <= merged;
    if (fill) begin
      line_data[idx] <= mem_res.data;
      line_tag[idx]  <= tag;
    end
  end

  // control FSM with registered CPU/memory handshakes
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      line_vld <= '0;
      cpu_res  <= '0;
      mem_req  <= '0;
      r_rw     <= 1'b0;
      r_addr   <= '0;
      r_data   <= '0;
      r_wmask  <= '0;
`ifdef DCACHE_STATS_EN
      hit_count  <= '0;
      miss_count <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (cpu_req.valid) begin
          r_rw    <= cpu_req.rw;
          r_addr  <= cpu_req.addr[31:2];
          r_data  <= cpu_req.data;
          r_wmask <= cpu_req.wmask;
          state   <= LOOKUP;
        end
        LOOKUP: begin
          if (!r_rw) begin
            if (hit) begin
              cpu_res <= '{ready: 1'b1, data: line_data[idx]};
              state   <= RESP;
            end else begin
              mem_req <= '{valid: 1'b1, rw: 1'b0, addr: {r_addr, 2'b00}, data: 32'h0, wmask: 32'h0};
              state   <= MEM_RD;
            end
`ifdef DCACHE_STATS_EN
            if (hit) hit_count  <= hit_count + 32'd1;
            else     miss_count <= miss_count + 32'd1;
`endif
          end else begin
            // write-through: memory is always written, hit or miss
            mem_req <= '{valid: 1'b1, rw: 1'b1, addr: {r_addr, 2'b00}, data: r_data, wmask: r_wmask};
            state   <= MEM_WR;
          end
        end
        MEM_RD: if (mem_res.ready) begin
          line_vld[idx] <= 1'b1;
          cpu_res       <= '{ready: 1'b1, data: mem_res.data};
          mem_req       <= '0;
          state         <= RESP;
        end
        MEM_WR: if (mem_res.ready) begin
          cpu_res <= '{ready: 1'b1, data: 32'h0};
          mem_req <= '0;
          state   <= RESP;
        end
        RESP: begin
          cpu_res.ready <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_core.sv
// Self-checking bench for dcache_core: directed vector table, reset-abort
// sequence, and randomized traffic against a word-level memory/residency model.
module tb_dcache_core;
  import dcache_interface::*;

  logic     clk = 1'b0;
  logic     rst = 1'b1;
  cpu_req_t cpu_req = '0;
  cpu_res_t cpu_res;
  cpu_req_t mem_req;
  cpu_res_t mem_res = '0;
`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  dcache_core #(.NUM_LINES(16)) dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_res(cpu_res),
    .mem_req(mem_req), .mem_res(mem_res)
`ifdef DCACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // reference model: backing memory by word address, plus which word each line holds
  logic [31:0] mem [int unsigned];
  bit          cv [16];
  logic [29:0] cw [16];
  int          exp_hits = 0;
  int          exp_misses = 0;

  function automatic logic [31:0] mem_rd(input logic [29:0] w);
    if (mem.exists(w)) return mem[w];
    return (32'(w) * 32'h9E37_79B1) + 32'h0123_4567;
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    return cv[a[5:2]] && (cw[a[5:2]] == a[31:2]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) cv[i] = 1'b0;
    exp_hits = 0;
    exp_misses = 0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // one CPU transaction; the bench also plays the backing memory with 'dly' wait cycles
  task automatic xact(input bit rw, input logic [31:0] addr, data, wmask, input int dly,
                      output logic [31:0] rdata, output int lat, output int nmem,
                      output logic [31:0] maddr, output bit mrw, output logic [31:0] mdata,
                      output logic [3:0] mwm);
    int w;
    bit done;
    w = 0; done = 0; nmem = 0; lat = 0; rdata = 'x;
    maddr = 'x; mrw = 0; mdata = 'x; mwm = 'x;
    @(negedge clk);
    cpu_req = '{valid: 1'b1, rw: rw, addr: addr, data: data, wmask: wmask};
    for (int c = 1; c <= 60 && !done; c++) begin
      @(negedge clk);
      mem_res = '0;
      if (cpu_res.ready) begin
        rdata = cpu_res.data;
        lat = c;
        done = 1;
        cpu_req = '0;
      end else if (mem_req.valid) begin
        if (w == 0) begin
          maddr = mem_req.addr; mrw = mem_req.rw;
          mdata = mem_req.data; mwm = mem_req.wmask[3:0];
        end
        if (w == dly) begin
          nmem++;
          mem_res = '{ready: 1'b1, data: mem_req.rw ? 32'h0 : mem_rd(mem_req.addr[31:2])};
          w = 0;
        end else w++;
      end
    end
    cpu_req = '0;
    mem_res = '0;
    chk("response_timeout", 32'(done), 32'd1);
    @(negedge clk);
    chk("ready_one_cycle", 32'(cpu_res.ready), 32'd0);
  endtask

  task automatic run_vec(input string tag, input bit rw, input logic [31:0] addr, data, wmask,
                         input int dly, input bit exp_hit, input logic [31:0] exp_data);
    logic [31:0] rdata, maddr, mdata;
    logic [3:0]  mwm;
    int          lat, nmem;
    bit          mrw, fast;
    xact(rw, addr, data, wmask, dly, rdata, lat, nmem, maddr, mrw, mdata, mwm);
    fast = exp_hit && !rw;
    chk({tag, "_data"}, rdata, exp_data);
    chk({tag, "_mem_count"}, 32'(nmem), fast ? 32'd0 : 32'd1);
    chk({tag, "_latency"}, 32'(lat), fast ? 32'd2 : 32'(3 + dly));
    if (!fast) begin
      chk({tag, "_mem_addr"}, maddr, {addr[31:2], 2'b00});
      chk({tag, "_mem_rw"}, 32'(mrw), 32'(rw));
      if (rw) begin
        chk({tag, "_mem_data"}, mdata, data);
        chk({tag, "_mem_wmask"}, 32'(mwm), 32'(wmask[3:0]));
      end
    end
    // advance the model
    if (!rw) begin
      if (model_hit(addr)) exp_hits++;
      else begin
        exp_misses++;
        cv[addr[5:2]] = 1'b1;
        cw[addr[5:2]] = addr[31:2];
      end
    end else begin
      logic [31:0] m;
      m = mem_rd(addr[31:2]);
      for (int b = 0; b < 4; b++) if (wmask[b]) m[8*b +: 8] = data[8*b +: 8];
      mem[addr[31:2]] = m;
    end
  endtask

  typedef struct {
    bit          rw;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] wmask;
    int          dly;
    bit          hit;
    logic [31:0] exp;
  } vec_t;

  vec_t vt [9];

  initial begin
    vt[0] = '{0, 32'h0000_0040, 32'h0,         32'h0,         3, 0, 32'hDEAD_BEEF};
    vt[1] = '{0, 32'h0000_0042, 32'h0,         32'h0,         0, 1, 32'hDEAD_BEEF};
    vt[2] = '{1, 32'h0000_0040, 32'h1122_3344, 32'h0000_0003, 1, 1, 32'h0};
    vt[3] = '{0, 32'h0000_0040, 32'h0,         32'h0,         0, 1, 32'hDEAD_3344};
    vt[4] = '{1, 32'h0000_0080, 32'hAABB_CCDD, 32'h0000_000F, 0, 0, 32'h0};
    vt[5] = '{0, 32'h0000_0040, 32'h0,         32'h0,         0, 1, 32'hDEAD_3344};
    vt[6] = '{1, 32'h0000_0040, 32'h5566_7788, 32'hFFFF_FFF0, 2, 1, 32'h0};
    vt[7] = '{0, 32'h0000_0041, 32'h0,         32'h0,         0, 1, 32'hDEAD_3344};
    vt[8] = '{0, 32'h0000_0080, 32'h0,         32'h0,         1, 0, 32'hAABB_CCDD};

    mem[30'h10] = 32'hDEAD_BEEF;
    model_reset();

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_cpu_ready", 32'(cpu_res.ready), 32'd0);
    chk("rst_cpu_data", cpu_res.data, 32'd0);
    chk("rst_mem_valid", 32'(mem_req.valid), 32'd0);
    chk("rst_mem_addr", mem_req.addr, 32'd0);
    chk("rst_mem_fields", mem_req.data | mem_req.wmask | 32'(mem_req.rw), 32'd0);
    rst = 1'b0;

    // directed table
    for (int i = 0; i < 9; i++) begin
      run_vec($sformatf("vec%0d", i), vt[i].rw, vt[i].addr, vt[i].data, vt[i].wmask,
              vt[i].dly, vt[i].hit, vt[i].exp);
`ifdef DCACHE_STATS_EN
      if (i == 1) begin
        chk("stats_hit", hit_count, 32'd1);
        chk("stats_miss", miss_count, 32'd1);
      end
`endif
    end

    // reset while a miss to 0x400 is waiting on memory
    begin
      bit seen, got_ready;
      seen = 0; got_ready = 0;
      @(negedge clk);
      cpu_req = '{valid: 1'b1, rw: 1'b0, addr: 32'h0000_0400, data: 32'h0, wmask: 32'h0};
      for (int c = 0; c < 20 && !seen; c++) begin
        @(negedge clk);
        if (mem_req.valid) seen = 1;
      end
      chk("abort_mem_seen", 32'(seen), 32'd1);
      chk("abort_mem_addr", mem_req.addr, 32'h0000_0400);
      rst = 1'b1;
      cpu_req = '0;
      @(negedge clk);
      chk("abort_mem_valid", 32'(mem_req.valid), 32'd0);
      chk("abort_cpu_ready", 32'(cpu_res.ready), 32'd0);
      rst = 1'b0;
      model_reset();
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        if (cpu_res.ready || mem_req.valid) got_ready = 1;
      end
      chk("abort_no_resp", 32'(got_ready), 32'd0);
      run_vec("after_rst_0", 0, 32'h0000_0000, 0, 0, 1, 0, mem_rd(30'h0));
      run_vec("after_rst_80", 0, 32'h0000_0080, 0, 0, 0, 0, 32'hAABB_CCDD);
    end

    // randomized traffic over a few tags aliasing onto four lines
    for (int n = 0; n < 60; n++) begin
      logic [31:0] a, d, wm;
      bit rw;
      a  = 32'($urandom_range(0, 2)) * 32'd64 + 32'($urandom_range(0, 3)) * 32'd4 + 32'($urandom_range(0, 3));
      rw = 1'($urandom_range(0, 1));
      d  = $urandom();
      wm = $urandom();
      run_vec($sformatf("rnd%0d", n), rw, a, d, wm, $urandom_range(0, 3),
              model_hit(a), rw ? 32'h0 : mem_rd(a[31:2]));
    end

`ifdef DCACHE_STATS_EN
    chk("stats_hit_final", hit_count, 32'(exp_hits));
    chk("stats_miss_final", miss_count, 32'(exp_misses));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "simulation time limit");
  end

endmodule
